// File: rtl/alu_ctr_pkg.sv
// Shared constants for the ALU control sequencer: ctr operation codes,
// main-control alu_op classes and the handshake FSM state encoding.
package alu_ctr_pkg;

   localparam int CTR_BASE_W = 3;

   localparam logic [CTR_BASE_W-1:0] CTR_ADD = 3'd0;
   localparam logic [CTR_BASE_W-1:0] CTR_SUB = 3'd1;
   localparam logic [CTR_BASE_W-1:0] CTR_AND = 3'd2;
   localparam logic [CTR_BASE_W-1:0] CTR_OR  = 3'd3;
   localparam logic [CTR_BASE_W-1:0] CTR_XOR = 3'd4;
   localparam logic [CTR_BASE_W-1:0] CTR_SLT = 3'd5;
   localparam logic [CTR_BASE_W-1:0] CTR_SLL = 3'd6;
   localparam logic [CTR_BASE_W-1:0] CTR_MUL = 3'd7;

   localparam int OP_RTYPE = 0;
   localparam int OP_ADD   = 1;
   localparam int OP_SUB   = 2;
   localparam int OP_AND   = 3;
   localparam int OP_OR    = 4;
   localparam int OP_SLT   = 5;
   localparam int OP_XOR   = 6;
   localparam int OP_ILL   = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_ctr_decode.sv
// Combinational decode of alu_op/func into a ctr code plus illegal and
// multi-cycle (MUL) flags. Undecodable requests map to ADD with illegal set.
module alu_ctr_decode
   import alu_ctr_pkg::*;
#(
   parameter int OP_W   = 3,
   parameter int FUNC_W = 5,
   parameter int CTR_W  = 3
) (
   input  logic [OP_W-1:0]   alu_op,
   input  logic [FUNC_W-1:0] func,
   output logic [CTR_W-1:0]  ctr,
   output logic              illegal,
   output logic              is_mul
);

   // Upper func bits only; the low three select the R-type operation.
   logic [FUNC_W-1:0] hi_bits;

   genvar gi;
   generate
      for (gi = 0; gi < FUNC_W; gi++) begin : g_hi
         if (gi < CTR_BASE_W) begin : g_lo
            assign hi_bits[gi] = 1'b0;
         end else begin : g_up
            assign hi_bits[gi] = func[gi];
         end
      end
   endgenerate

   logic [CTR_BASE_W-1:0] code;
   logic                  ill;
   logic                  mul;

   always_comb begin
      code = CTR_ADD;
      ill  = 1'b0;
      mul  = 1'b0;
      case (alu_op)
         OP_W'(OP_RTYPE): begin
            if (|hi_bits) begin
               ill = 1'b1;
            end else begin
               // R-type func numbering coincides with the ctr code numbering
               code = func[CTR_BASE_W-1:0];
               mul  = (func[CTR_BASE_W-1:0] == CTR_MUL);
            end
         end
         OP_W'(OP_ADD): code = CTR_ADD;
         OP_W'(OP_SUB): code = CTR_SUB;
         OP_W'(OP_AND): code = CTR_AND;
         OP_W'(OP_OR):  code = CTR_OR;
         OP_W'(OP_SLT): code = CTR_SLT;
         OP_W'(OP_XOR): code = CTR_XOR;
         default:       ill  = 1'b1;
      endcase
   end

   assign ctr     = CTR_W'(code);
   assign illegal = ill;
   assign is_mul  = mul;

endmodule

// File: rtl/alu_ctr_seq.sv
// Registered ALU control decoder with valid/ready on both sides and a busy
// window for MUL. Optional illegal-request counter under ALU_CTR_STATS_EN.
module alu_ctr_seq
   import alu_ctr_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int FUNC_W  = 5,
   parameter int CTR_W   = 3,
   parameter int MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   alu_op,
   input  logic [FUNC_W-1:0] func,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTR_W-1:0]  ctr,
   output logic              illegal,
   output logic              multi
`ifdef ALU_CTR_STATS_EN
   ,
   output logic [7:0]        illegal_cnt
`endif
);

   localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

   logic [CTR_W-1:0] dec_ctr;
   logic             dec_illegal;
   logic             dec_is_mul;

   alu_ctr_decode #(
      .OP_W   (OP_W),
      .FUNC_W (FUNC_W),
      .CTR_W  (CTR_W)
   ) u_decode (
      .alu_op  (alu_op),
      .func    (func),
      .ctr     (dec_ctr),
      .illegal (dec_illegal),
      .is_mul  (dec_is_mul)
   );

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CTR_W-1:0] ctr_reg, ctr_next;
   logic             illegal_reg, illegal_next;
   logic             multi_reg, multi_next;
   logic             accept;
   logic             do_load;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ctr_next     = ctr_reg;
      illegal_next = illegal_reg;
      multi_next   = multi_reg;
      in_ready     = 1'b0;
      do_load      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            in_ready = !flush;
            do_load  = accept;
         end
         ST_BUSY: begin
            if (cnt_reg == '0) state_next = ST_HOLD;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         ST_HOLD: begin
            in_ready = out_ready && !flush;
            if (out_ready) begin
               do_load = accept;
               if (!accept) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (do_load) begin
         ctr_next     = dec_ctr;
         illegal_next = dec_illegal;
         multi_next   = dec_is_mul;
         if (dec_is_mul) begin
            state_next = ST_BUSY;
            cnt_next   = CNT_W'(MUL_LAT - 2);
         end else begin
            state_next = ST_HOLD;
         end
      end

      // in_ready is already low here, so no load can coincide with a flush
      if (flush) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         ctr_reg     <= '0;
         illegal_reg <= 1'b0;
         multi_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ctr_reg     <= ctr_next;
         illegal_reg <= illegal_next;
         multi_reg   <= multi_next;
      end
   end

   assign out_valid = (state_reg == ST_HOLD);
   assign ctr       = ctr_reg;
   assign illegal   = illegal_reg;
   assign multi     = multi_reg;

`ifdef ALU_CTR_STATS_EN
   logic [7:0] illegal_cnt_reg, illegal_cnt_next;

   always_comb begin
      illegal_cnt_next = illegal_cnt_reg;
      if (accept && dec_illegal && (illegal_cnt_reg != 8'hFF))
         illegal_cnt_next = illegal_cnt_reg + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) illegal_cnt_reg <= 8'd0;
      else        illegal_cnt_reg <= illegal_cnt_next;
   end

   assign illegal_cnt = illegal_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_ctr_seq.sv
// Self-checking bench for alu_ctr_seq: directed scenarios then random traffic,
// all checked against a latency/decode-table reference model.
module tb_alu_ctr_seq;

   localparam int OP_W    = 3;
   localparam int FUNC_W  = 5;
   localparam int CTR_W   = 3;
   localparam int MUL_LAT = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [OP_W-1:0]   alu_op = '0;
   logic [FUNC_W-1:0] func = '0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CTR_W-1:0]  ctr;
   logic              illegal;
   logic              multi;
`ifdef ALU_CTR_STATS_EN
   logic [7:0]        illegal_cnt;
`endif

   always #5 clk = ~clk;

   alu_ctr_seq #(
      .OP_W    (OP_W),
      .FUNC_W  (FUNC_W),
      .CTR_W   (CTR_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .func      (func),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ctr       (ctr),
      .illegal   (illegal),
      .multi     (multi)
`ifdef ALU_CTR_STATS_EN
      ,
      .illegal_cnt (illegal_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding result that becomes visible at a
   // known cycle number, decoded from plain lookup tables.
   int rtype_tbl[8];
   int class_tbl[8];
   int  cyc      = 0;
   bit  known    = 0;
   bit  pending  = 0;
   int  ready_at = 0;
   int  m_ctr    = 0;
   bit  m_ill    = 0;
   bit  m_mul    = 0;
   int  m_icnt   = 0;

   task automatic ref_decode(input int op, input int fn, output int c, output bit il, output bit mu);
      c = 0; il = 0; mu = 0;
      if (op == 0) begin
         if (fn / 8 != 0) il = 1;
         else begin
            c  = rtype_tbl[fn % 8];
            mu = (fn % 8 == 7);
         end
      end else if (op >= 1 && op <= 6) begin
         c = class_tbl[op];
      end else begin
         il = 1;
      end
   endtask

   // One clock cycle: drive, check, advance model, wait for the edge.
   task automatic step(input bit rn, input bit v, input int op, input int fn,
                       input bit ordy, input bit fl);
      bit exp_ov, exp_ir, acc;
      int c; bit il, mu;
      @(negedge clk);
      rst_n = rn; in_valid = v; alu_op = OP_W'(op); func = FUNC_W'(fn);
      out_ready = ordy; flush = fl;
      #1;
      exp_ov = pending && (cyc >= ready_at);
      exp_ir = !fl && (!pending || (exp_ov && ordy));
      if (known) begin
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         chk("ctr", 32'(ctr), 32'(m_ctr));
         chk("illegal", 32'(illegal), 32'(m_ill));
         chk("multi", 32'(multi), 32'(m_mul));
         if (rn) chk("in_ready", 32'(in_ready), 32'(exp_ir));
`ifdef ALU_CTR_STATS_EN
         chk("illegal_cnt", 32'(illegal_cnt), 32'(m_icnt));
`endif
      end
      if (!rn) begin
         known = 1; pending = 0; m_ctr = 0; m_ill = 0; m_mul = 0; m_icnt = 0;
      end else if (fl) begin
         pending = 0;
      end else begin
         acc = v && exp_ir;
         if (exp_ov && ordy) pending = 0;
         if (acc) begin
            ref_decode(op, fn, c, il, mu);
            pending  = 1;
            ready_at = cyc + (mu ? MUL_LAT : 1);
            m_ctr = c; m_ill = il; m_mul = mu;
            if (il && m_icnt < 255) m_icnt++;
         end
      end
      cyc++;
      @(posedge clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, ordy, 0);
   endtask

   initial begin
      rtype_tbl = '{0, 1, 2, 3, 4, 5, 6, 7};
      class_tbl = '{0, 0, 1, 2, 3, 5, 4, 0};

      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // SUB via R-type
      step(1, 1, 0, 5'b00001, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("sub_ctr", 32'(ctr), 32'd1);

      // MUL latency
      step(1, 1, 0, 5'b00111, 1, 0);
      idle(MUL_LAT + 1, 1);

      // two illegal requests
      step(1, 1, 0, 5'b11111, 1, 0);
      step(1, 1, 7, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("ill_flag", 32'(illegal), 32'd1);

      // ADD held under backpressure, then SUB accepted on release
      step(1, 1, 1, 0, 0, 0);
      idle(5, 0);
      step(1, 1, 2, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("sub_after_hold", 32'(ctr), 32'd1);

      // flush two cycles into a MUL, with a competing request
      step(1, 1, 0, 5'b00111, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 1, 1, 0, 1, 1);
      idle(MUL_LAT + 1, 1);

      // reset during BUSY
      step(1, 1, 0, 5'b00111, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);

      for (int i = 0; i < 600; i++) begin
         int fn;
         fn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                          : int'($urandom_range(0, 7));
         step(1, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)), fn,
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      end
      idle(MUL_LAT + 2, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_ctr_seq.md
# alu_ctr_seq

Parametrised, registered successor to the combinational ALU control decoder. Decodes a main-control `ALUop` plus instruction `func` field into an ALU operation code, adds a valid/ready handshake on both sides, and sequences multi-cycle operations (MUL) by holding a busy state for a configurable latency. Sits between the main control unit and the ALU/multiplier in the execute stage.

## Interface
- `OP_W`, 3: width of `alu_op`.
- `FUNC_W`, 5 (≥3): width of `func`.
- `CTR_W`, 3 (≥3): width of `ctr`.
- `MUL_LAT`, 4 (≥2): accept-to-`out_valid` latency for MUL.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `alu_op`  in  OP_W  main-control ALU class.
- `func`  in  FUNC_W  R-type function field.
- `flush`  in  1  kill in-flight and held result.
- `out_valid`  out  1  `ctr` valid.
- `out_ready`  in  1  consumer takes result when `out_valid && out_ready`.
- `ctr`  out  CTR_W  ALU operation code.
- `illegal`  out  1  request did not decode; qualified by `out_valid`.
- `multi`  out  1  result came from a multi-cycle op; qualified by `out_valid`.

## Operation
- Decode, `alu_op`: 0 = R-type (use `func`); 1 ADD; 2 SUB; 3 AND; 4 OR; 5 SLT; 6 XOR; 7 illegal. Values ≥8 (if `OP_W` > 3) illegal.
- R-type `func[2:0]`: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 MUL. Any nonzero bit in `func[FUNC_W-1:3]` is illegal.
- `ctr` codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, MUL 7; zero-extended to `CTR_W`.
- Illegal: `ctr`=ADD, `illegal`=1, completes as a single-cycle op.
- FSM `IDLE`, `BUSY`, `HOLD`:
  - `IDLE`: `in_ready`=1. Single-cycle accept goes to `HOLD`. MUL accept goes to `BUSY` with counter loaded to `MUL_LAT`-2.
  - `BUSY`: `in_ready`=0. Counter decrements each cycle. At 0, go to `HOLD`.
  - `HOLD`: `out_valid`=1 and `in_ready`=`out_ready`. On `out_ready`, a concurrent accept re-enters `HOLD` or `BUSY`; otherwise go to `IDLE`.
- `ctr`, `illegal` and `multi` are registered at accept and are stable until consumed.
- `flush`: next state is `IDLE`, `out_valid`=0, counter=0. `in_ready` is forced 0 in the flush cycle, so flush beats a simultaneous accept.
- Reset: state `IDLE`, `out_valid`=0, `ctr`=0, `illegal`=0, `multi`=0, counter=0. `in_ready` reads 1 from the first cycle after reset deasserts. Reset mid-`BUSY` discards the op.

## Timing
- Single-cycle op: `out_valid` is asserted in the cycle after accept (latency 1).
- MUL: `out_valid` is asserted exactly `MUL_LAT` cycles after accept.
- Full throughput for back-to-back single-cycle ops while `out_ready`=1.
- `in_ready` is combinational from state, `out_ready` and `flush` only; no path from `in_valid`.

## Configuration
- `ALU_CTR_STATS_EN` defined: adds output `illegal_cnt` (8 bits).
  - Increments on each accepted illegal request.
  - Saturates at 255.
  - Cleared by reset only; `flush` does not clear it.
- `ALU_CTR_STATS_EN` undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `alu_ctr_pkg` holds:
  - ctr code constants (ADD…MUL);
  - `alu_op` class constants;
  - FSM state encoding.
- One combinational sub-module, `alu_ctr_decode`: takes `alu_op` and `func`, returns `ctr`, `illegal` and `is_mul`. `alu_ctr_seq` contains the FSM, counter and output register.

## Test plan
- Reset, then `alu_op`=0, `func`=5'b00001, `out_ready`=1 → next cycle `out_valid`=1, `ctr`=1, `illegal`=0, `multi`=0.
- `alu_op`=0, `func`=5'b00111, `MUL_LAT`=4 → `in_ready`=0 for 3 cycles; `out_valid`=1 at cycle 4 with `ctr`=7, `multi`=1.
- `func`=5'b11111 with `alu_op`=0, then `alu_op`=3'b111 → both give `ctr`=0, `illegal`=1. With `ALU_CTR_STATS_EN`, `illegal_cnt`=2.
- `out_ready`=0 for 5 cycles after an ADD result → `ctr`/`out_valid` held and `in_ready`=0. On `out_ready`=1, a new SUB is accepted in the same cycle; `ctr`=1 follows next cycle.
- MUL accepted, `flush` 2 cycles later together with `in_valid` → `in_ready`=0 that cycle, no `out_valid` for the MUL, FSM `IDLE` next cycle.
- `rst_n`=0 during `BUSY` → next cycle all outputs at reset values, `in_ready`=1 after release.
